// File: rtl/load_extract_unit_if.sv
// load_extract_unit_if: request/response handshake bundle for the load formatter.
// The master side drives requests and rsp_ready; the slave side is the formatter.
interface load_extract_unit_if #(
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned OFF_W = $clog2(DATA_W / 8);

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [OFF_W-1:0]  req_off;
    logic [DATA_W-1:0] mdr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_misaligned;

    modport master (
        output req_valid, req_size, req_signed, req_off, mdr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_misaligned
    );

    modport slave (
        input  req_valid, req_size, req_signed, req_off, mdr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_misaligned
    );
endinterface

// File: rtl/load_extract_unit.sv
// load_extract_unit: registered load-data formatter (lane select, zero/sign extend).
// Optional macro LOAD_UNALIGNED_EN: merge misaligned half/word loads across two
// consecutive memory beats instead of flagging them with rsp_misaligned.
module load_extract_unit #(
    parameter int unsigned DATA_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    load_extract_unit_if.slave bus
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    // Byte at lane offset idx of a memory word, honouring lane order.
    function automatic logic [7:0] lane(input logic [DATA_W-1:0] word, input int unsigned idx);
        if (BIG_ENDIAN) return word[DATA_W-1-8*idx -: 8];
        else            return word[8*idx +: 8];
    endfunction

    // Builds the access byte sequence starting at off (bytes past the end of lo_word
    // wrap into hi_word), then extracts and extends it according to size/sign.
    function automatic logic [DATA_W-1:0] fmt(
        input logic [DATA_W-1:0] lo_word,
        input logic [DATA_W-1:0] hi_word,
        input logic [OFF_W-1:0]  off,
        input logic [1:0]        size,
        input logic              sgn
    );
        logic [DATA_W-1:0] seq;
        logic [DATA_W-1:0] res;
        logic [15:0]       half;
        logic              ext;
        int unsigned       pos;
        seq = '0;
        res = '0;
        ext = 1'b0;
        for (int unsigned k = 0; k < NB; k++) begin
            pos = (32'(off) + k) % NB;
            seq[8*k +: 8] = (k < NB - 32'(off)) ? lane(lo_word, pos) : lane(hi_word, pos);
        end
        half = BIG_ENDIAN ? {seq[7:0], seq[15:8]} : {seq[15:8], seq[7:0]};
        case (size)
            SZ_BYTE: begin
                ext = sgn & seq[7];
                res = {{(DATA_W-8){ext}}, seq[7:0]};
            end
            SZ_HALF: begin
                ext = sgn & half[15];
                res = {{(DATA_W-16){ext}}, half};
            end
            default: begin
                for (int unsigned k = 0; k < NB; k++) begin
                    if (BIG_ENDIAN) res[DATA_W-1-8*k -: 8] = seq[8*k +: 8];
                    else            res[8*k +: 8]          = seq[8*k +: 8];
                end
            end
        endcase
        return res;
    endfunction

    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_mis;

    logic              w_req_ready;
    logic              w_accept;
    logic              w_misaligned;
    logic              w_load;
    logic              w_mis;
    logic [DATA_W-1:0] w_data;

    assign w_req_ready = !r_rsp_valid || bus.rsp_ready;
    assign w_accept    = bus.req_valid && w_req_ready;

    // Alignment check on the incoming beat; bytes are never misaligned.
    always_comb begin
        w_misaligned = 1'b0;
        case (bus.req_size)
            SZ_BYTE: w_misaligned = 1'b0;
            SZ_HALF: w_misaligned = bus.req_off[0];
            default: w_misaligned = (bus.req_off != '0);
        endcase
    end

`ifdef LOAD_UNALIGNED_EN
    typedef enum logic {IDLE, WAIT_HI} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [DATA_W-1:0] r_hold_data;
    logic [1:0]        r_hold_size;
    logic              r_hold_signed;
    logic [OFF_W-1:0]  r_hold_off;
    logic              w_hold_load;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // First-beat hold register; only bytes r_hold_off..NB-1 are consumed later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_data   <= '0;
            r_hold_size   <= '0;
            r_hold_signed <= 1'b0;
            r_hold_off    <= '0;
        end else if (w_hold_load) begin
            r_hold_data   <= bus.mdr;
            r_hold_size   <= bus.req_size;
            r_hold_signed <= bus.req_signed;
            r_hold_off    <= bus.req_off;
        end
    end

    // Next-state and datapath control: split misaligned beats, merge on the second.
    always_comb begin
        w_next_state = r_state;
        w_hold_load  = 1'b0;
        w_load       = 1'b0;
        w_mis        = 1'b0;
        w_data       = fmt(bus.mdr, bus.mdr, bus.req_off, bus.req_size, bus.req_signed);
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_misaligned) begin
                        w_hold_load  = 1'b1;
                        w_next_state = WAIT_HI;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            WAIT_HI: begin
                if (w_accept) begin
                    w_load       = 1'b1;
                    w_data       = fmt(r_hold_data, bus.mdr, r_hold_off, r_hold_size, r_hold_signed);
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end
`else
    // Single-beat path: misaligned beats complete as zero data with the trap flag.
    always_comb begin
        w_load = w_accept;
        w_mis  = w_misaligned;
        w_data = w_misaligned ? '0 : fmt(bus.mdr, bus.mdr, bus.req_off, bus.req_size, bus.req_signed);
    end
`endif

    // Output register: loads on a completing beat, holds under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_mis   <= 1'b0;
        end else if (w_load) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_data;
            r_rsp_mis   <= w_mis;
        end else if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign bus.req_ready      = w_req_ready;
    assign bus.rsp_valid      = r_rsp_valid;
    assign bus.rsp_data       = r_rsp_data;
    assign bus.rsp_misaligned = r_rsp_mis;
endmodule

// File: tb/tb_load_extract_unit.sv
// tb_load_extract_unit: directed vector table plus hand-written multi-beat sequences.
module tb_load_extract_unit;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    load_extract_unit_if #(.DATA_W(32)) bus ();

    load_extract_unit #(.DATA_W(32), .BIG_ENDIAN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  off;
        logic [31:0] mdr;
        logic [31:0] exp_data;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] size, input logic sgn, input logic [1:0] off,
                         input logic [31:0] mdr);
        bus.req_valid  = 1'b1;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_off    = off;
        bus.mdr        = mdr;
    endtask

    task automatic add(input logic [1:0] size, input logic sgn, input logic [1:0] off,
                       input logic [31:0] mdr, input logic [31:0] exp_data, input logic exp_mis);
        vec_t v;
        v.size = size; v.sgn = sgn; v.off = off; v.mdr = mdr;
        v.exp_data = exp_data; v.exp_mis = exp_mis;
        vecs.push_back(v);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_off    = 2'b00;
        bus.mdr        = 32'h0;
        bus.rsp_ready  = 1'b0;

        add(2'b10, 1'b1, 2'd3, 32'h12345680, 32'hFFFFFF80, 1'b0);
        add(2'b10, 1'b0, 2'd0, 32'h12345680, 32'h00000012, 1'b0);
        add(2'b01, 1'b0, 2'd2, 32'hAABBCCDD, 32'h0000CCDD, 1'b0);
        add(2'b01, 1'b1, 2'd2, 32'hAABBCCDD, 32'hFFFFCCDD, 1'b0);
        add(2'b00, 1'b0, 2'd0, 32'hAABBCCDD, 32'hAABBCCDD, 1'b0);
        add(2'b11, 1'b1, 2'd0, 32'h01020304, 32'h01020304, 1'b0);
        add(2'b01, 1'b1, 2'd0, 32'h7FFF0000, 32'h00007FFF, 1'b0);
        add(2'b10, 1'b1, 2'd1, 32'h00FF0000, 32'hFFFFFFFF, 1'b0);
        add(2'b10, 1'b0, 2'd2, 32'h0000AB00, 32'h000000AB, 1'b0);
`ifndef LOAD_UNALIGNED_EN
        add(2'b00, 1'b0, 2'd1, 32'h11223344, 32'h00000000, 1'b1);
        add(2'b01, 1'b1, 2'd1, 32'h11223344, 32'h00000000, 1'b1);
        add(2'b11, 1'b0, 2'd2, 32'h11223344, 32'h00000000, 1'b1);
        add(2'b01, 1'b1, 2'd3, 32'hFFFF8001, 32'h00000000, 1'b1);
        add(2'b10, 1'b1, 2'd3, 32'h11223381, 32'hFFFFFF81, 1'b0);
`endif

        // Reset state
        step();
        step();
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_data", bus.rsp_data, 32'h0);
        check("reset_rsp_mis", 32'(bus.rsp_misaligned), 32'd0);
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);
        reset = 1'b0;
        bus.rsp_ready = 1'b1;
        step();

        // Vector table, back-to-back beats (one response per cycle)
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].size, vecs[i].sgn, vecs[i].off, vecs[i].mdr);
            step();
            check($sformatf("vec%0d_valid", i), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("vec%0d_data", i), bus.rsp_data, vecs[i].exp_data);
            check($sformatf("vec%0d_mis", i), 32'(bus.rsp_misaligned), 32'(vecs[i].exp_mis));
        end
        bus.req_valid = 1'b0;
        step();
        check("drain_valid", 32'(bus.rsp_valid), 32'd0);

        // Backpressure: response A stalls, beat B waits, then both move on one edge
        bus.rsp_ready = 1'b0;
        drive(2'b00, 1'b0, 2'd0, 32'h0A0B0C0D);
        step();
        check("bp_a_valid", 32'(bus.rsp_valid), 32'd1);
        check("bp_a_data", bus.rsp_data, 32'h0A0B0C0D);
        drive(2'b00, 1'b0, 2'd0, 32'hB0B1B2B3);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp_ready_low%0d", c), 32'(bus.req_ready), 32'd0);
            step();
            check($sformatf("bp_hold%0d", c), bus.rsp_data, 32'h0A0B0C0D);
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_ready_high", 32'(bus.req_ready), 32'd1);
        step();
        check("bp_b_valid", 32'(bus.rsp_valid), 32'd1);
        check("bp_b_data", bus.rsp_data, 32'hB0B1B2B3);
        bus.req_valid = 1'b0;
        step();
        check("bp_drain", 32'(bus.rsp_valid), 32'd0);

`ifdef LOAD_UNALIGNED_EN
        // Merged word, with an idle gap between beats
        drive(2'b00, 1'b0, 2'd1, 32'h11223344);
        step();
        check("mw_beat1_novalid", 32'(bus.rsp_valid), 32'd0);
        bus.req_valid = 1'b0;
        step();
        step();
        check("mw_gap_novalid", 32'(bus.rsp_valid), 32'd0);
        drive(2'b10, 1'b1, 2'd2, 32'h55667788);
        step();
        bus.req_valid = 1'b0;
        check("mw_valid", 32'(bus.rsp_valid), 32'd1);
        check("mw_data", bus.rsp_data, 32'h22334455);
        check("mw_mis", 32'(bus.rsp_misaligned), 32'd0);
        step();

        // Merged signed half spanning the word boundary
        drive(2'b01, 1'b1, 2'd3, 32'h000000F0);
        step();
        check("mh_beat1_novalid", 32'(bus.rsp_valid), 32'd0);
        drive(2'b00, 1'b0, 2'd0, 32'h01FFFFFF);
        step();
        bus.req_valid = 1'b0;
        check("mh_valid", 32'(bus.rsp_valid), 32'd1);
        check("mh_data", bus.rsp_data, 32'hFFFFF001);
        step();
`endif

        // Reset after a misaligned first beat, then a plain aligned word
        drive(2'b00, 1'b0, 2'd1, 32'h11223344);
        step();
        bus.req_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_wait_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_wait_data", bus.rsp_data, 32'h0);
        check("rst_wait_ready", 32'(bus.req_ready), 32'd1);
        drive(2'b00, 1'b0, 2'd0, 32'hCAFEF00D);
        step();
        bus.req_valid = 1'b0;
        check("rst_word_valid", 32'(bus.rsp_valid), 32'd1);
        check("rst_word_data", bus.rsp_data, 32'hCAFEF00D);
        check("rst_word_mis", 32'(bus.rsp_misaligned), 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/load_extract_unit.md
# load_extract_unit

Parametrised, registered load-data formatter for the multicycle MIPS datapath. Sits between the memory data register and the register-file write-back mux. It selects the byte/halfword/word lane by address offset, zero- or sign-extends it, and handles flow control with a valid/ready handshake. Compile-time option: merge misaligned loads from two consecutive memory beats instead of flagging them.

## Interface
- DATA_W, 32, memory word width in bits; a multiple of 8 and ≥ 32.
- BIG_ENDIAN, 1, byte lane order.
  - 1: byte offset 0 = mdr[DATA_W-1 -: 8] (MIPS order).
  - 0: byte offset 0 = mdr[7:0].
- Derived: NB = DATA_W/8; OFF_W = $clog2(NB).

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request beat present.
- req_ready  out  1  beat accepted when req_valid && req_ready at a clock edge.
- req_size  in  2  access size:
  - 00 word (DATA_W bits)
  - 01 half
  - 10 byte
  - 11 reserved, treated as word.
- req_signed  in  1  1 = sign-extend byte/half; 0 = zero-extend.
- req_off  in  OFF_W  byte offset of the access within the word.
- mdr  in  DATA_W  memory word for this beat.
- rsp_valid  out  1  rsp_data/rsp_misaligned valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DATA_W  formatted, extended load data.
- rsp_misaligned  out  1  access was misaligned and not merged.

## Operation
- Misaligned cases:
  - half with odd req_off;
  - word/reserved with req_off ≠ 0.
  - Byte is never misaligned.
- Extension:
  - byte: bits [7:0] hold the selected byte; upper DATA_W-8 bits = sign bit if req_signed, else 0.
  - half: bits [15:0] hold the halfword, with byte at the lower offset as the most significant when BIG_ENDIAN=1 (least significant when BIG_ENDIAN=0); upper bits extended as for byte.
  - word: passed unextended, in lane order.
- FSM states: IDLE and WAIT_HI (WAIT_HI exists only with LOAD_UNALIGNED_EN).
  - IDLE, accepted beat, aligned → format, load output register, stay IDLE.
  - IDLE, accepted beat, misaligned, merge enabled:
    - save bytes req_off..NB-1, req_size, req_signed and req_off into a hold register;
    - go to WAIT_HI;
    - produce no response.
  - WAIT_HI, accepted beat → take the remaining leading bytes (offset 0 upward) from this mdr, merge, format with the saved size/sign, load output register, go to IDLE. req_size/req_signed/req_off of this beat are ignored.
- Output register: holds its value while rsp_valid && !rsp_ready.
- req_ready = !rsp_valid || rsp_ready, in both states (combinational from rsp_ready). Full throughput is one response per cycle for aligned accesses.
- Reset, in any state including WAIT_HI: state → IDLE; hold register discarded; rsp_valid = 0, rsp_data = 0, rsp_misaligned = 0. req_ready = 1 after reset.

## Timing
- Latency: rsp_valid rises the cycle after the final beat is accepted.
  - Aligned: 1 cycle.
  - Merged: 1 cycle after the second beat; no bound on the gap between beats.
- If a response is consumed and a new beat accepted on the same edge, the output register reloads with no bubble.
- rsp_data and rsp_misaligned change only on an edge where the output register loads.
- req_valid low in WAIT_HI: stay in WAIT_HI indefinitely.

## Configuration
- LOAD_UNALIGNED_EN defined: misaligned half/word loads take two beats and are merged. rsp_misaligned is never 1.
- LOAD_UNALIGNED_EN undefined: no WAIT_HI state or hold register. A misaligned beat completes in one beat with rsp_data = 0 and rsp_misaligned = 1 (trap hook for the control unit).

## Test plan
All cases use DATA_W=32, BIG_ENDIAN=1.
- Byte: size 10, signed, off 3, mdr 0x12345680 → next cycle rsp_valid=1, rsp_data 0xFFFFFF80. Unsigned, off 0 → 0x00000012.
- Half/word: size 01, unsigned, off 2, mdr 0xAABBCCDD → 0x0000CCDD. Signed → 0xFFFFCCDD. Size 00, off 0 → 0xAABBCCDD.
- Backpressure: hold rsp_ready=0 for 3 cycles with req_valid=1 → req_ready=0, rsp_data stable, no beat consumed. rsp_ready=1 → next beat accepted on that same edge.
- Merge (macro on): word, off 1, beat1 0x11223344, beat2 0x55667788 → rsp 0x22334455 one cycle after beat2. Half, off 3, signed, beats 0x000000F0/0x01FFFFFF → 0xFFFFF001.
- Misaligned (macro off): word, off 1, mdr 0x11223344 → rsp_data 0x00000000, rsp_misaligned=1, single beat.
- Reset in WAIT_HI: after beat1, assert reset one cycle → rsp_valid=0, state IDLE. Aligned word 0xCAFEF00D then returns 0xCAFEF00D with no merge.
